// File: rtl/regfile_np.sv
// Parametrised multi-read-port register file: registered reads, write-first bypass, stall hold,
// post-reset clear sweep. Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_np #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*WIDTH-1:0] rdata,
  output logic                 ready
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          clr_ptr_q, clr_ptr_d;
  logic [NRD*WIDTH-1:0]   rdata_q, rdata_d;
  logic [WIDTH-1:0]       arr [DEPTH];

  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [WIDTH-1:0]       wr_data;

  // Registers at or beyond DEPTH only exist when DEPTH is not a power of 2.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path through the block can infer a latch.
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    rdata_d   = rdata_q;
    wr_en     = 1'b0;
    wr_addr   = clr_ptr_q;
    wr_data   = '0;

    if (state_q == CLEAR) begin
      rdata_d = '0;
      wr_en   = rst_n;
      if (clr_ptr_q == AW'(DEPTH - 1)) begin
        state_d = RUN;
      end else begin
        clr_ptr_d = clr_ptr_q + 1'b1;
      end
    end else if (en) begin
      if (we && addr_ok(waddr)) begin
        wr_en   = 1'b1;
        wr_addr = waddr;
        wr_data = wdata;
      end
      // Bypass is keyed on the raw write address; a dropped write can only alias a read that returns 0 anyway.
      for (int p = 0; p < NRD; p++) begin
        if (!addr_ok(raddr[p*AW +: AW])) begin
          rdata_d[p*WIDTH +: WIDTH] = '0;
        end else if (we && (waddr == raddr[p*AW +: AW])) begin
          rdata_d[p*WIDTH +: WIDTH] = wdata;
        end else begin
          rdata_d[p*WIDTH +: WIDTH] = arr[raddr[p*AW +: AW]];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      rdata_q   <= rdata_d;
    end
  end

  // NOTE: the array has no reset; the clear sweep zeroes it one entry per cycle after reset instead.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      arr[wr_addr] <= wr_data;
    end
  end

  assign rdata = rdata_q;
  assign ready = (state_q == RUN);

endmodule

// File: tb/tb_regfile_np.sv
// Self-checking bench for regfile_np: a 32-deep and a 20-deep instance share stimulus
// and are compared each cycle against an array-based reference model.
module tb_regfile_np;

  localparam int W   = 8;
  localparam int NRD = 2;
  localparam int AW  = 5;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [W-1:0]      wdata;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*W-1:0]  rdata_a, rdata_b;
  logic              ready_a, ready_b;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: index 0 is the 32-deep instance, index 1 the 20-deep one.
  logic [W-1:0] mem   [2][32];
  bit           m_rdy [2];
  int           m_cnt [2];
  logic [W-1:0] m_rd  [2][2];

  regfile_np #(.WIDTH(W), .DEPTH(32), .NRD(NRD)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a), .ready(ready_a)
  );

  regfile_np #(.WIDTH(W), .DEPTH(20), .NRD(NRD)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .ready(ready_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int depth_of(input int d);
    return (d == 0) ? 32 : 20;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rdy[d] = 1'b0;
      m_cnt[d] = 0;
      for (int p = 0; p < 2; p++) m_rd[d][p] = '0;
    end
  endtask

  // Applies the effect of one rising edge with the inputs currently driven.
  task automatic model_edge();
    int a;
    int dep;
    if (!rst_n) return;
    for (int d = 0; d < 2; d++) begin
      dep = depth_of(d);
      if (!m_rdy[d]) begin
        mem[d][m_cnt[d]] = '0;
        m_cnt[d]++;
        if (m_cnt[d] == dep) m_rdy[d] = 1'b1;
      end else if (en) begin
        for (int p = 0; p < 2; p++) begin
          a = int'(raddr[p*AW +: AW]);
          if (a >= dep || (ZR && a == 0))       m_rd[d][p] = '0;
          else if (we && int'(waddr) == a)      m_rd[d][p] = wdata;
          else                                  m_rd[d][p] = mem[d][a];
        end
        if (we && int'(waddr) < dep && !(ZR && waddr == '0)) mem[d][waddr] = wdata;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "/a.ready"}, 32'(ready_a), 32'(m_rdy[0]));
    check({tag, "/a.rd0"}, 32'(rdata_a[7:0]),  32'(m_rd[0][0]));
    check({tag, "/a.rd1"}, 32'(rdata_a[15:8]), 32'(m_rd[0][1]));
    check({tag, "/b.ready"}, 32'(ready_b), 32'(m_rdy[1]));
    check({tag, "/b.rd0"}, 32'(rdata_b[7:0]),  32'(m_rd[1][0]));
    check({tag, "/b.rd1"}, 32'(rdata_b[15:8]), 32'(m_rd[1][1]));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic set_in(input logic e, input logic w, input int wa, input int wd,
                        input int r0, input int r1);
    en    = e;
    we    = w;
    waddr = AW'(wa);
    wdata = W'(wd);
    raddr = {AW'(r1), AW'(r0)};
  endtask

  // Called just after an edge: reset lands mid-cycle and must act without a clock.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all(tag);
    check({tag, "/a.rdata_all"}, 32'(rdata_a), 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic sweep(input string tag);
    for (int k = 1; k <= 32; k++) begin
      step(tag);
      if (k == 19 || k == 20) check({tag, "/b.ready_edge"}, 32'(ready_b), 32'(k >= 20));
      if (k == 31 || k == 32) check({tag, "/a.ready_edge"}, 32'(ready_a), 32'(k >= 32));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b1, 1'b1, 5, 8'hAA, 5, 3);
    model_reset();
    #3;
    compare_all("por");
    step("in_reset");
    rst_n = 1'b1;

    // Writes presented during the sweep must be ignored.
    sweep("sweep1");
    set_in(1'b1, 1'b0, 0, 0, 5, 5);
    step("rd5");
    check("clear_write_ignored", 32'(rdata_a[7:0]), 32'h00);

    set_in(1'b1, 1'b1, 3, 8'h5C, 0, 1);
    step("wr3");
    set_in(1'b1, 1'b0, 0, 0, 3, 3);
    step("rd3");
    check("rd3_p0", 32'(rdata_a[7:0]),  32'h5C);
    check("rd3_p1", 32'(rdata_a[15:8]), 32'h5C);

    set_in(1'b1, 1'b1, 2, 8'h11, 3, 3);
    step("wr2");
    set_in(1'b1, 1'b1, 7, 8'h81, 7, 2);
    step("bypass");
    check("bypass_p0", 32'(rdata_a[7:0]),  32'h81);
    check("bypass_p1", 32'(rdata_a[15:8]), 32'h11);

    set_in(1'b0, 1'b1, 7, 8'hFF, 7, 2);
    for (int k = 0; k < 3; k++) begin
      step("stall");
      check("stall_hold", 32'(rdata_a[7:0]), 32'h81);
    end
    set_in(1'b1, 1'b0, 0, 0, 7, 7);
    step("after_stall");
    check("stall_no_write", 32'(rdata_a[7:0]), 32'h81);

    set_in(1'b1, 1'b1, 25, 8'h33, 0, 0);
    step("wr25");
    set_in(1'b1, 1'b0, 0, 0, 25, 3);
    step("rd25");
    check("oor_read_b", 32'(rdata_b[7:0]),  32'h00);
    check("oor_keep_b", 32'(rdata_b[15:8]), 32'h5C);
    check("inrange_a",  32'(rdata_a[7:0]),  32'h33);

    set_in(1'b1, 1'b1, 0, 8'hEE, 0, 0);
    step("zero_reg");
    check("zero_reg_bypass", 32'(rdata_a[7:0]), ZR ? 32'h00 : 32'hEE);

    for (int k = 0; k < 400; k++) begin
      int wa;
      int r0;
      int r1;
      wa = $urandom_range(0, 31);
      r0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 31);
      r1 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 31);
      set_in(($urandom_range(0, 7) != 0), 1'($urandom), wa, int'($urandom_range(0, 255)), r0, r1);
      step("rand");
    end

    // Reset in RUN with a write pending, then again at cycle 10 of the sweep.
    set_in(1'b1, 1'b1, 9, 8'h77, 9, 9);
    async_reset("rst_run");
    for (int k = 0; k < 10; k++) step("sweep_part");
    async_reset("rst_mid");
    sweep("sweep2");
    set_in(1'b1, 1'b0, 0, 0, 9, 5);
    step("rd9");
    check("pending_write_lost", 32'(rdata_a[7:0]), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
